serial_port: RTL and testbench

//  Memory-mapped UART responder on the CPU data bus: the device end of the CPU's DI/DO strobes.
//  CPU writes are pushed into a TX FIFO and serialised 8N1 on tx.

---
 rtl/serial_port.sv | 204 ++++++++++++++++++++
 tb/tb_serial_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port.sv
// Memory-mapped UART device: CPU writes feed an 8N1 transmitter through a TX FIFO,
// received bytes land in a one-byte holding register with status flags for polling.
//
// state   | meaning (same encoding for the TX and RX machines)
// S_IDLE  | line idle; TX waits for FIFO data, RX waits for a falling edge
// S_START | start bit; RX re-checks the line at mid-bit to reject glitches
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit; RX commits the byte at mid-bit if the line is high
module serial_port #(
    parameter logic [7:0] BASE_ADDR    = 8'h00,
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_bar,
    input  logic [7:0]  addr,
    input  logic [15:0] bus_in,
    input  logic        DI,
    input  logic        DO,
    output logic [15:0] bus_out,
    output logic        oe,
    output logic        tx,
    input  logic        rx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic sel_data, sel_stat, rd_data, rd_stat, wr_data, wr_stat;
    logic unused_bus;

    assign sel_data   = (addr == BASE_ADDR);
    assign sel_stat   = (addr == BASE_ADDR + 8'd1);
    assign rd_data    = DO & sel_data;
    assign rd_stat    = DO & sel_stat;
    // A simultaneous read wins; the write half of the cycle is discarded.
    assign wr_data    = DI & ~DO & sel_data;
    assign wr_stat    = DI & ~DO & sel_stat;
    assign unused_bus = ^bus_in[15:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr, fifo_count;
    logic        tx_full, tx_empty, push, tx_pop, tx_idle;

    assign fifo_count = wr_ptr - rd_ptr;
    assign tx_full    = (fifo_count == FULL_CNT);
    assign tx_empty   = (wr_ptr == rd_ptr);
    assign push       = wr_data & ~tx_full;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= bus_in[7:0];
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX FSM ----------------
    state_t          tx_state, tx_state_nx;
    logic [TW-1:0]   tx_cnt;
    logic [2:0]      tx_idx;
    logic [7:0]      tx_shift;
    logic            tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) tx_state <= S_IDLE;
        else            tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        tx_pop      = 1'b0;
        case (tx_state)
            S_IDLE:  if (!tx_empty) begin
                         tx_state_nx = S_START;
                         tx_pop      = 1'b1;
                     end
            S_START: if (tx_tick) tx_state_nx = S_DATA;
            S_DATA:  if (tx_tick && tx_idx == 3'd7) tx_state_nx = S_STOP;
            S_STOP:  if (tx_tick) begin
                         // Chain straight into the next start bit when data is waiting.
                         tx_state_nx = tx_empty ? S_IDLE : S_START;
                         tx_pop      = ~tx_empty;
                     end
            default: tx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
        end else begin
            if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
            else                               tx_cnt <= tx_cnt + 1'b1;
            if (tx_pop) begin
                tx_shift <= fifo_mem[rd_ptr[PW-1:0]];
                tx_idx   <= '0;
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_idx <= tx_idx + 1'b1;
            end
        end
    end

    always_comb begin
        case (tx_state)
            S_START: tx = 1'b0;
            S_DATA:  tx = tx_shift[tx_idx];
            default: tx = 1'b1;
        endcase
    end

    assign tx_idle = tx_empty & (tx_state == S_IDLE);

    // ---------------- RX ----------------
    logic            rx_meta, rx_s, rx_prev;
    state_t          rx_state, rx_state_nx;
    logic [TW-1:0]   rx_cnt;
    logic [2:0]      rx_idx;
    logic [7:0]      rx_shift, rx_byte;
    logic            rx_tick, rx_half, rx_commit, rx_valid, overrun;

    assign rx_tick = (rx_cnt == BIT_LAST);
    assign rx_half = (rx_cnt == HALF_LAST);

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_state <= rx_state_nx;
        end
    end

    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_prev && !rx_s) rx_state_nx = S_START;
            S_START: if (rx_half) rx_state_nx = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_idx == 3'd7) rx_state_nx = S_STOP;
            S_STOP:  if (rx_tick) rx_state_nx = S_IDLE;
            default: rx_state_nx = S_IDLE;
        endcase
    end

    assign rx_commit = (rx_state == S_STOP) & rx_tick & rx_s;

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_state == S_IDLE || rx_state_nx != rx_state || rx_tick) rx_cnt <= '0;
            else                                                          rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == S_START) begin
                rx_idx <= '0;
            end else if (rx_state == S_DATA && rx_tick) begin
                rx_shift <= {rx_s, rx_shift[7:1]};
                rx_idx   <= rx_idx + 1'b1;
            end
            if (rx_commit && (!rx_valid || rd_data)) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rd_data) begin
                rx_valid <= 1'b0;
            end
            if (rx_commit && rx_valid && !rd_data) overrun <= 1'b1;
            else if (wr_stat && bus_in[3])         overrun <= 1'b0;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        bus_out = '0;
        if (rd_data)      bus_out = {8'h00, rx_byte};
        else if (rd_stat) bus_out = {12'h000, overrun, tx_idle, tx_full, rx_valid};
    end

    assign oe = rd_data | rd_stat;

endmodule

// File: tb/tb_serial_port.sv
// Scoreboard bench for serial_port: stimulus pushes expected TX frames and read data
// into queues, independent monitors decode the tx line and bus reads and compare.
module tb_serial_port;
    localparam int         CPB   = 16;
    localparam int         DEPTH = 8;
    localparam logic [7:0] BASE  = 8'h20;
    localparam logic [7:0] STAT  = BASE + 8'd1;

    logic        clk = 1'b0;
    logic        reset_bar;
    logic [7:0]  addr;
    logic [15:0] bus_in;
    logic        DI, DO;
    logic [15:0] bus_out;
    logic        oe, tx, rx;

    serial_port #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_bar(reset_bar), .addr(addr), .bus_in(bus_in),
        .DI(DI), .DO(DO), .bus_out(bus_out), .oe(oe), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         push;
        int         start;
    } frame_t;

    frame_t      hist[$];
    frame_t      exp_tx[$];
    logic [15:0] exp_rd[$];
    int          last_end = 0;
    logic        rxv_m = 1'b0, ovr_m = 1'b0;
    logic [7:0]  rxb_m = 8'h00;
    bit          mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bytes accepted but not yet taken by the transmitter just before edge n.
    function automatic int fifo_occ(input int n);
        int c = 0;
        foreach (hist[i]) if (hist[i].push < n && hist[i].start >= n) c++;
        return c;
    endfunction

    function automatic bit tx_busy(input int n);
        foreach (hist[i]) if (hist[i].start <= n - 1 && n - 1 < hist[i].start + 10 * CPB) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] status_m(input int n);
        int occ = fifo_occ(n);
        return {12'h000, ovr_m, (occ == 0 && !tx_busy(n)), (occ == DEPTH), rxv_m};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        int     n;
        frame_t f;
        n = cyc;
        addr = a; bus_in = d; DI = 1'b1; DO = 1'b0;
        if (a == BASE) begin
            if (fifo_occ(n) < DEPTH) begin
                f.data  = d[7:0];
                f.push  = n;
                f.start = (n + 1 > last_end) ? n + 1 : last_end;
                last_end = f.start + 10 * CPB;
                hist.push_back(f);
                if (mon_on) exp_tx.push_back(f);
            end
        end else if (a == STAT) begin
            if (d[3]) ovr_m = 1'b0;
        end
        tick();
        DI = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, input bit with_di);
        int n;
        n = cyc;
        addr = a; DO = 1'b1; DI = with_di; bus_in = 16'($urandom);
        if (a == BASE) begin
            exp_rd.push_back({8'h00, rxb_m});
            rxv_m = 1'b0;
        end else if (a == STAT) begin
            exp_rd.push_back(status_m(n));
        end else begin
            #1;
            check("unmapped_oe", oe, 0);
            check("unmapped_bus", bus_out, 0);
        end
        tick();
        DO = 1'b0; DI = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_ok;
        repeat (CPB) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        if (stop_ok) begin
            if (!rxv_m) begin
                rxb_m = b;
                rxv_m = 1'b1;
            end else begin
                ovr_m = 1'b1;
            end
        end
    endtask

    task automatic rx_glitch();
        rx = 1'b0;
        repeat (CPB / 4) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
    endtask

    task automatic wait_tx_drain();
        int lim;
        lim = last_end + 2 * CPB;
        while (cyc < lim) tick();
    endtask

    // Read monitor: every cycle the DUT drives the bus, one expectation is consumed.
    always @(negedge clk) begin
        if (oe === 1'b1) begin
            if (exp_rd.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rd_unexpected: got %h expected no read", bus_out);
            end else begin
                check("bus_read", bus_out, exp_rd.pop_front());
            end
        end
    end

    // TX monitor: decodes each frame at bit centres and checks its start cycle.
    initial begin : tx_mon
        int         s;
        logic [7:0] d;
        logic       sb, pb;
        frame_t     f;
        forever begin
            @(negedge clk);
            if (mon_on && tx === 1'b0) begin
                s = cyc - 1;
                repeat (CPB / 2 - 1) @(negedge clk);
                sb = tx;
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    d[b] = tx;
                end
                repeat (CPB) @(negedge clk);
                pb = tx;
                if (exp_tx.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL tx_unexpected: got byte %h expected no frame", d);
                end else begin
                    f = exp_tx.pop_front();
                    check("tx_start_cycle", s, f.start);
                    check("tx_byte", d, f.data);
                    check("tx_framing", {sb, pb}, 2'b01);
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        logic [7:0] a;
        reset_bar = 1'b0; addr = 8'h00; bus_in = 16'h0000; DI = 1'b0; DO = 1'b0; rx = 1'b1;
        repeat (3) tick();
        check("rst_tx", tx, 1);
        check("rst_oe", oe, 0);
        check("rst_bus", bus_out, 0);
        reset_bar = 1'b1;
        repeat (4) tick();
        mon_on = 1'b1;
        cpu_read(STAT, 1'b0);

        // Reset in the middle of a frame
        mon_on = 1'b0;
        cpu_write(BASE, 16'h00C3);
        repeat (3 * CPB) tick();
        #2 reset_bar = 1'b0;
        #1 check("midframe_rst_tx", tx, 1);
        tick();
        reset_bar = 1'b1;
        hist.delete(); last_end = 0; rxv_m = 1'b0; ovr_m = 1'b0; rxb_m = 8'h00;
        repeat (2) tick();
        cpu_read(STAT, 1'b0);
        mon_on = 1'b1;

        // Single frame, high byte ignored
        cpu_write(BASE, 16'h1255);
        wait_tx_drain();

        // Back-to-back writes overflow the FIFO
        for (int i = 0; i < 10; i++) cpu_write(BASE, 16'h0030 + 16'(i));
        cpu_read(STAT, 1'b0);
        wait_tx_drain();
        cpu_read(STAT, 1'b0);

        // Receive, read back, status
        send_rx(8'hA5, 1'b1);
        cpu_read(STAT, 1'b0);
        cpu_read(BASE, 1'b0);
        cpu_read(STAT, 1'b0);

        // Overrun and clear
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        cpu_read(STAT, 1'b0);
        cpu_read(BASE, 1'b0);
        cpu_write(STAT, 16'h0008);
        cpu_read(STAT, 1'b0);

        // Glitch and framing error
        rx_glitch();
        cpu_read(STAT, 1'b0);
        send_rx(8'h5A, 1'b0);
        cpu_read(STAT, 1'b0);
        cpu_read(BASE, 1'b0);

        // Randomised traffic
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    int k = $urandom_range(1, 4);
                    for (int j = 0; j < k; j++) cpu_write(BASE, 16'($urandom));
                end
                3: cpu_read(STAT, 1'b0);
                4: cpu_read(BASE, 1'b0);
                5: send_rx(8'($urandom), $urandom_range(0, 5) != 0);
                6: rx_glitch();
                7: cpu_write(STAT, 16'($urandom));
                8: begin
                    a = BASE + 8'(2 + $urandom_range(0, 200));
                    if ($urandom_range(0, 1) == 1) cpu_read(a, 1'b0);
                    else                           cpu_write(a, 16'($urandom));
                end
                default: cpu_read(($urandom_range(0, 1) == 1) ? BASE : STAT, 1'b1);
            endcase
            repeat ($urandom_range(0, 20)) tick();
        end

        wait_tx_drain();
        cpu_read(STAT, 1'b0);
        repeat (4) tick();
        check("tx_leftover", exp_tx.size(), 0);
        check("rd_leftover", exp_rd.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
